usb_reader: RTL and testbench

- Receive-side counterpart of the USB_writer transmitter: samples the 2-bit differential line {D+, D-} once per shift strobe.
- Detects SYNC, NRZI-decodes the payload LSB-first into a packet buffer, detects EOP, then classifies the packet by PID.
- Presents the packet, with data_select encoded exactly as the transmitter consumes it, to the protocol layer through a valid/read handshake.
- Sits between the line interface and the packet-decode logic.

---
 rtl/usb_pkg.sv | 59 +++++
 rtl/usb_nrzi_decoder.sv | 46 ++++
 rtl/usb_reader.sv | 212 +++++++++++++++++++++
 tb/tb_usb_reader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB line/packet definitions for the writer and reader.
// Holds line-state codes, the SYNC pattern, data_select encodings, PID
// class codes, packet lengths and the packet-acceptance helper.
package usb_pkg;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_SE1 = 2'b11;

    // SYNC symbol i is K when bit i is set: K J K J K J K K
    localparam logic [7:0] SYNC_K_MASK = 8'b1101_0101;

    localparam logic [2:0] SEL_TOKEN     = 3'b000;
    localparam logic [2:0] SEL_DATA      = 3'b001;
    localparam logic [2:0] SEL_HANDSHAKE = 3'b010;
    localparam logic [2:0] SEL_SPECIAL   = 3'b011;

    localparam logic [1:0] PID_CLASS_SPECIAL   = 2'b00;
    localparam logic [1:0] PID_CLASS_TOKEN     = 2'b01;
    localparam logic [1:0] PID_CLASS_HANDSHAKE = 2'b10;
    localparam logic [1:0] PID_CLASS_DATA      = 2'b11;

    localparam logic [6:0] LEN_HANDSHAKE = 7'd8;
    localparam logic [6:0] LEN_TOKEN     = 7'd24;
    localparam logic [6:0] LEN_MAX       = 7'd88;

    typedef enum logic [1:0] {LC_J, LC_K, LC_SE0, LC_SE1} line_class_t;
    typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_PAYLOAD, ST_EOP, ST_ERR} rx_state_t;

    typedef struct packed {
        logic       ok;
        logic [2:0] sel;
    } pkt_check_t;

    // PID upper nibble must be the complement of the lower nibble
    function automatic logic pid_ok(input logic [7:0] pid);
        return (pid[7:4] == ~pid[3:0]);
    endfunction

    // Length/PID acceptance of a received payload and its data_select code
    function automatic pkt_check_t check_packet(input logic [7:0] pid, input logic [6:0] count);
        pkt_check_t res;
        logic       len_ok;
        len_ok  = 1'b0;
        res.sel = SEL_SPECIAL;
        case (pid[1:0])
            PID_CLASS_TOKEN:     begin res.sel = SEL_TOKEN;     len_ok = (count == LEN_TOKEN); end
            PID_CLASS_DATA:      begin res.sel = SEL_DATA;
                                       len_ok = (count >= LEN_TOKEN) && (count <= LEN_MAX) && (count[2:0] == 3'b000); end
            PID_CLASS_HANDSHAKE: begin res.sel = SEL_HANDSHAKE; len_ok = (count == LEN_HANDSHAKE); end
            PID_CLASS_SPECIAL:   begin res.sel = SEL_SPECIAL;   len_ok = (count == LEN_TOKEN); end
            default:             begin res.sel = SEL_SPECIAL;   len_ok = 1'b0; end
        endcase
        res.ok = (count >= LEN_HANDSHAKE) && pid_ok(pid) && len_ok;
        return res;
    endfunction

endpackage

// File: rtl/usb_nrzi_decoder.sv
// NRZI line decoder: classifies the current line sample and decodes it
// against the previous J/K level (same level = 1, change = 0).
// Ports: clk, n_rst; shift (sample strobe); data_in {D+,D-};
// load_k (preset previous level to K at end of SYNC); track (follow the
// line while receiving payload); bit_value / line_class for the sample.
module usb_nrzi_decoder
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        shift,
    input  logic [1:0]  data_in,
    input  logic        load_k,
    input  logic        track,
    output logic        bit_value,
    output line_class_t line_class
);

    logic [1:0] prev_line_r;

    // Map the raw line pair to a line class
    always_comb begin
        line_class = LC_SE1;
        case (data_in)
            LINE_J:   line_class = LC_J;
            LINE_K:   line_class = LC_K;
            LINE_SE0: line_class = LC_SE0;
            LINE_SE1: line_class = LC_SE1;
            default:  line_class = LC_SE1;
        endcase
    end

    assign bit_value = (data_in == prev_line_r);

    // Previous-level register, only J/K samples move it
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_line_r <= LINE_J;
        end else if (shift && load_k) begin
            prev_line_r <= LINE_K;
        end else if (shift && track && ((line_class == LC_J) || (line_class == LC_K))) begin
            prev_line_r <= data_in;
        end
    end

endmodule

// File: rtl/usb_reader.sv
// USB receive path: SYNC detect, NRZI payload capture (LSB first), EOP
// detect, PID/length classification and a valid/read output handshake.
// Ports: clk, n_rst; data_in {D+,D-}; shift (bit strobe); read (consumer
// ack); data_out/bit_count/data_select (last good packet); packet_valid;
// overrun (unread packet replaced); rcv_error (1-cycle pulse); busy.
module usb_reader
    import usb_pkg::*;
#(
    parameter int MAX_BITS = 88,
    parameter int SYNC_LEN = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [1:0]          data_in,
    input  logic                shift,
    input  logic                read,
    output logic [MAX_BITS-1:0] data_out,
    output logic [2:0]          data_select,
    output logic [6:0]          bit_count,
    output logic                packet_valid,
    output logic                overrun,
    output logic                rcv_error,
    output logic                busy
);

    localparam int                IDX_W     = $clog2(SYNC_LEN);
    localparam logic [6:0]        MAX_COUNT = 7'(MAX_BITS);
    localparam logic [IDX_W-1:0]  SYNC_LAST = IDX_W'(SYNC_LEN - 1);

    rx_state_t           state_r;
    logic [IDX_W-1:0]    sync_idx_r;
    logic [1:0]          se0_run_r;
    logic [6:0]          count_r;
    logic [MAX_BITS-1:0] rx_buf_r;
    logic                rcv_error_r;
    logic                busy_r;
    logic [MAX_BITS-1:0] data_out_r;
    logic [2:0]          data_select_r;
    logic [6:0]          bit_count_r;
    logic                packet_valid_r;
    logic                overrun_r;

    logic                bit_s;
    line_class_t         line_class_s;
    line_class_t         sync_expect_s;
    logic                load_k_s;
    logic                track_s;
    logic                done_s;
    pkt_check_t          check_s;

    usb_nrzi_decoder u_nrzi (
        .clk        (clk),
        .n_rst      (n_rst),
        .shift      (shift),
        .data_in    (data_in),
        .load_k     (load_k_s),
        .track      (track_s),
        .bit_value  (bit_s),
        .line_class (line_class_s)
    );

    // Expected SYNC symbol and decoder control for the current state
    always_comb begin
        sync_expect_s = LC_J;
        load_k_s      = 1'b0;
        if (SYNC_K_MASK[sync_idx_r]) begin
            sync_expect_s = LC_K;
        end else begin
            sync_expect_s = LC_J;
        end
        if ((state_r == ST_SYNC) && (sync_idx_r == SYNC_LAST) && (line_class_s == sync_expect_s)) begin
            load_k_s = 1'b1;
        end else begin
            load_k_s = 1'b0;
        end
        track_s = (state_r == ST_PAYLOAD);
    end

    // Packet acceptance on the EOP-terminating J
    always_comb begin
        check_s = check_packet(rx_buf_r[7:0], count_r);
        if (shift && (state_r == ST_EOP) && (line_class_s == LC_J) && (se0_run_r >= 2'd2)) begin
            done_s = check_s.ok;
        end else begin
            done_s = 1'b0;
        end
    end

    // Receive FSM with capture buffer, error pulse and busy flag
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r     <= ST_IDLE;
            sync_idx_r  <= '0;
            se0_run_r   <= 2'd0;
            count_r     <= 7'd0;
            rx_buf_r    <= '0;
            rcv_error_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rcv_error_r <= 1'b0;
            if (shift) begin
                case (state_r)
                    ST_IDLE: begin
                        if (line_class_s == LC_K) begin
                            state_r    <= ST_SYNC;
                            busy_r     <= 1'b1;
                            sync_idx_r <= IDX_W'(1);
                            count_r    <= 7'd0;
                            rx_buf_r   <= '0;
                        end else if (line_class_s == LC_SE1) begin
                            state_r <= ST_ERR; busy_r <= 1'b1; rcv_error_r <= 1'b1; se0_run_r <= 2'd0;
                        end
                    end
                    ST_SYNC: begin
                        if (line_class_s != sync_expect_s) begin
                            state_r <= ST_ERR; rcv_error_r <= 1'b1; se0_run_r <= 2'd0;
                        end else if (sync_idx_r == SYNC_LAST) begin
                            state_r <= ST_PAYLOAD;
                        end else begin
                            sync_idx_r <= sync_idx_r + IDX_W'(1);
                        end
                    end
                    ST_PAYLOAD: begin
                        case (line_class_s)
                            LC_J, LC_K: begin
                                if (count_r == MAX_COUNT) begin
                                    state_r <= ST_ERR; rcv_error_r <= 1'b1; se0_run_r <= 2'd0;
                                end else begin
                                    rx_buf_r[count_r] <= bit_s;
                                    count_r           <= count_r + 7'd1;
                                end
                            end
                            LC_SE0: begin
                                state_r   <= ST_EOP;
                                se0_run_r <= 2'd1;
                            end
                            default: begin
                                state_r <= ST_ERR; rcv_error_r <= 1'b1; se0_run_r <= 2'd0;
                            end
                        endcase
                    end
                    ST_EOP: begin
                        case (line_class_s)
                            LC_SE0: begin
                                if (se0_run_r != 2'd3) se0_run_r <= se0_run_r + 2'd1;
                            end
                            LC_J: begin
                                if (se0_run_r >= 2'd2) begin
                                    // a rejected packet still ends cleanly in IDLE
                                    state_r     <= ST_IDLE;
                                    busy_r      <= 1'b0;
                                    rcv_error_r <= ~check_s.ok;
                                end else begin
                                    state_r <= ST_ERR; rcv_error_r <= 1'b1; se0_run_r <= 2'd0;
                                end
                            end
                            default: begin
                                state_r <= ST_ERR; rcv_error_r <= 1'b1; se0_run_r <= 2'd0;
                            end
                        endcase
                    end
                    ST_ERR: begin
                        // se0_run_r doubles as the "SE0 seen" flag here
                        case (line_class_s)
                            LC_SE0: se0_run_r <= 2'd1;
                            LC_J: begin
                                if (se0_run_r != 2'd0) begin
                                    state_r <= ST_IDLE;
                                    busy_r  <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Output register and valid/read/overrun handshake
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_out_r     <= '0;
            data_select_r  <= 3'b000;
            bit_count_r    <= 7'd0;
            packet_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else if (done_s) begin
            data_out_r     <= rx_buf_r;
            data_select_r  <= check_s.sel;
            bit_count_r    <= count_r;
            packet_valid_r <= 1'b1;
            overrun_r      <= packet_valid_r && !read;
        end else if (read) begin
            packet_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
        end
    end

    assign data_out     = data_out_r;
    assign data_select  = data_select_r;
    assign bit_count    = bit_count_r;
    assign packet_valid = packet_valid_r;
    assign overrun      = overrun_r;
    assign rcv_error    = rcv_error_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_usb_reader.sv
// Self-checking bench for usb_reader: frames are built from payload bits,
// NRZI-encoded and driven one symbol per shift strobe; a frame-level model
// predicts the outputs, compared against the DUT on every falling edge.
module tb_usb_reader;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    logic        clk     = 1'b0;
    logic        n_rst   = 1'b0;
    logic [1:0]  data_in = 2'b10;
    logic        shift   = 1'b0;
    logic        read    = 1'b0;
    logic [87:0] data_out;
    logic [2:0]  data_select;
    logic [6:0]  bit_count;
    logic        packet_valid, overrun, rcv_error, busy;

    usb_reader dut (
        .clk(clk), .n_rst(n_rst), .data_in(data_in), .shift(shift), .read(read),
        .data_out(data_out), .data_select(data_select), .bit_count(bit_count),
        .packet_valid(packet_valid), .overrun(overrun), .rcv_error(rcv_error), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // per-symbol event flags set by the driver: 1 = good packet, 2 = error pulse
    int          ev_kind = 0;
    logic        ev_busy = 1'b0;
    logic [87:0] ev_data = '0;
    logic [6:0]  ev_cnt  = 7'd0;
    logic [2:0]  ev_sel  = 3'd0;
    bit          rnd_read = 1'b0;

    logic [87:0] exp_data  = '0;
    logic [6:0]  exp_cnt   = 7'd0;
    logic [2:0]  exp_sel   = 3'd0;
    logic        exp_valid = 1'b0;
    logic        exp_ovr   = 1'b0;
    logic        exp_err   = 1'b0;
    logic        exp_busy  = 1'b0;

    task automatic check(input string name, input logic [87:0] got, input logic [87:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Frame acceptance from the packet rules: PID complement, class, length
    function automatic bit frame_good(input logic [87:0] b, input int n, output logic [2:0] sel);
        bit len_ok;
        sel    = 3'b011;
        len_ok = 1'b0;
        case (b[1:0])
            2'b01:   begin sel = 3'b000; len_ok = (n == 24); end
            2'b11:   begin sel = 3'b001; len_ok = (n >= 24) && (n <= 88) && (n % 8 == 0); end
            2'b10:   begin sel = 3'b010; len_ok = (n == 8); end
            default: begin sel = 3'b011; len_ok = (n == 24); end
        endcase
        return (n >= 8) && (b[7:4] == ~b[3:0]) && len_ok;
    endfunction

    // Reference model: apply the driver's frame events at each active edge
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            exp_data <= '0; exp_cnt <= 7'd0; exp_sel <= 3'd0;
            exp_valid <= 1'b0; exp_ovr <= 1'b0; exp_err <= 1'b0; exp_busy <= 1'b0;
        end else begin
            exp_err <= shift && (ev_kind == 2);
            if (shift) exp_busy <= ev_busy;
            if (shift && (ev_kind == 1)) begin
                exp_data  <= ev_data;
                exp_cnt   <= ev_cnt;
                exp_sel   <= ev_sel;
                exp_valid <= 1'b1;
                exp_ovr   <= exp_valid && !read;
            end else if (read) begin
                exp_valid <= 1'b0;
                exp_ovr   <= 1'b0;
            end
        end
    end

    // Compare process, every cycle on the falling edge
    always @(negedge clk) begin
        check("data_out", data_out, exp_data);
        check("bit_count", 88'(bit_count), 88'(exp_cnt));
        check("data_select", 88'(data_select), 88'(exp_sel));
        check("packet_valid", 88'(packet_valid), 88'(exp_valid));
        check("overrun", 88'(overrun), 88'(exp_ovr));
        check("rcv_error", 88'(rcv_error), 88'(exp_err));
        check("busy", 88'(busy), 88'(exp_busy));
    end

    // One symbol on one shift strobe, then 0-2 idle cycles; starts/ends at posedge+1
    task automatic put_sym(input logic [1:0] s, input logic busy_after, input int kind);
        data_in = s;
        shift   = 1'b1;
        ev_busy = busy_after;
        ev_kind = kind;
        read    = rnd_read ? ($urandom_range(0, 3) == 0) : 1'b0;
        @(posedge clk); #1;
        shift   = 1'b0;
        ev_kind = 0;
        read    = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [87:0] raw, input int n, input int bad_sync, input int eop_n);
        logic [1:0]  sync_seq [8];
        logic [1:0]  lvl;
        logic [87:0] b;
        logic [2:0]  sel;
        bit          good;
        sync_seq = '{K, J, K, J, K, J, K, K};
        b = '0;
        for (int i = 0; i < n; i++) b[i] = raw[i];
        good    = frame_good(b, n, sel);
        ev_data = b;
        ev_cnt  = 7'(n);
        ev_sel  = sel;
        for (int i = 0; i < 8; i++) begin
            if (i == bad_sync) begin
                put_sym((sync_seq[i] == K) ? J : K, 1'b1, 2);
                repeat ($urandom_range(1, 4)) put_sym(($urandom_range(0, 1) == 1) ? J : K, 1'b1, 0);
                put_sym(SE0, 1'b1, 0);
                put_sym(J, 1'b0, 0);
                put_sym(J, 1'b0, 0);
                return;
            end
            put_sym(sync_seq[i], 1'b1, 0);
        end
        lvl = K;
        for (int i = 0; i < n; i++) begin
            if (b[i] == 1'b0) lvl = (lvl == K) ? J : K;
            put_sym(lvl, 1'b1, 0);
        end
        repeat (eop_n) put_sym(SE0, 1'b1, 0);
        if (eop_n >= 2) begin
            put_sym(J, 1'b0, good ? 1 : 2);
        end else begin
            put_sym(J, 1'b1, 2);
            put_sym(SE0, 1'b1, 0);
            put_sym(J, 1'b0, 0);
        end
        put_sym(J, 1'b0, 0);
    endtask

    task automatic do_read();
        read = 1'b1;
        @(posedge clk); #1;
        read = 1'b0;
    endtask

    initial begin
        logic [87:0] raw;
        logic [3:0]  nib;
        logic [1:0]  sync_seq [8];
        int          n, bad, eop;
        sync_seq = '{K, J, K, J, K, J, K, K};

        @(negedge clk);
        check("rst_data_out", data_out, 88'h0);
        check("rst_valid", 88'(packet_valid), 88'h0);
        check("rst_busy", 88'(busy), 88'h0);
        #12 n_rst = 1'b1;
        @(posedge clk); #1;
        repeat (3) put_sym(J, 1'b0, 0);

        // handshake ACK
        send_frame(88'hD2, 8, -1, 3);
        check("ack_byte", 88'(data_out[7:0]), 88'hD2);
        check("ack_count", 88'(bit_count), 88'd8);
        check("ack_select", 88'(data_select), 88'h2);
        check("ack_valid", 88'(packet_valid), 88'h1);
        do_read();
        check("ack_read_clears", 88'(packet_valid), 88'h0);

        // token PID 0x69, addr/endp 0x2A5, crc 0x0A
        send_frame({64'h0, 5'h0A, 11'h2A5, 8'h69}, 24, -1, 3);
        check("tok_select", 88'(data_select), 88'h0);
        check("tok_count", 88'(bit_count), 88'd24);
        check("tok_data", data_out, 88'h52A569);

        // DATA0 88 bits, left unread, then a handshake overwrites it
        raw = '0;
        raw[7:0]   = 8'hC3;
        raw[39:8]  = $urandom();
        raw[71:40] = $urandom();
        raw[87:72] = 16'($urandom());
        send_frame(raw, 88, -1, 2);
        check("data_select", 88'(data_select), 88'h1);
        send_frame(88'hD2, 8, -1, 4);
        check("ovr_data", data_out, 88'hD2);
        check("ovr_flag", 88'(overrun), 88'h1);
        do_read();
        check("ovr_read_valid", 88'(packet_valid), 88'h0);
        check("ovr_read_flag", 88'(overrun), 88'h0);

        // corrupt SYNC, then a good token
        send_frame(88'hD2, 8, 3, 3);
        check("badsync_valid", 88'(packet_valid), 88'h0);
        send_frame({64'h0, 5'h0A, 11'h2A5, 8'h69}, 24, -1, 3);
        check("after_badsync", data_out, 88'h52A569);

        // bad PID and truncated token leave the held packet alone
        send_frame(88'h55, 8, -1, 3);
        send_frame(88'h2A569, 16, -1, 3);
        check("reject_valid", 88'(packet_valid), 88'h1);
        check("reject_data", data_out, 88'h52A569);

        // asynchronous reset in the middle of a payload
        for (int i = 0; i < 8; i++) put_sym(sync_seq[i], 1'b1, 0);
        repeat (5) put_sym(($urandom_range(0, 1) == 1) ? J : K, 1'b1, 0);
        #2 n_rst = 1'b0;
        #1;
        check("arst_data", data_out, 88'h0);
        check("arst_valid", 88'(packet_valid), 88'h0);
        check("arst_busy", 88'(busy), 88'h0);
        check("arst_count", 88'(bit_count), 88'h0);
        @(posedge clk); #1 n_rst = 1'b1;
        repeat (2) put_sym(J, 1'b0, 0);
        send_frame(88'hD2, 8, -1, 3);
        check("post_rst_ack", data_out, 88'hD2);

        // randomized frames with random reads
        rnd_read = 1'b1;
        for (int f = 0; f < 40; f++) begin
            raw[31:0]  = $urandom();
            raw[63:32] = $urandom();
            raw[87:64] = 24'($urandom());
            if ($urandom_range(0, 3) != 0) begin
                nib = 4'($urandom());
                raw[7:0] = {~nib, nib};
            end
            n   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 88) : 8 * $urandom_range(1, 11);
            bad = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : -1;
            eop = $urandom_range(1, 4);
            send_frame(raw, n, bad, eop);
        end
        rnd_read = 1'b0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        n_bad++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
